// File: rtl/mod3_pkg.sv
// Shared types and remainder arithmetic for the MSB-first divisible-by-3 serial transmitter.
package mod3_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClr   = 2'd1,
        StShift = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic [1:0] R0 = 2'b00;
    localparam logic [1:0] R1 = 2'b01;
    localparam logic [1:0] R2 = 2'b10;

    // (2*rem + bit_in) mod 3; the unreachable encoding 3 behaves like R0.
    function automatic logic [1:0] mod3_next(input logic [1:0] rem, input logic bit_in);
        logic [1:0] nxt;
        unique case (rem)
            R1:      nxt = bit_in ? R0 : R2;
            R2:      nxt = bit_in ? R2 : R1;
            default: nxt = bit_in ? R1 : R0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mod3_rem_track.sv
// Running remainder (mod 3) of the bits sent so far, MSB first.
module mod3_rem_track
    import mod3_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       step_i,
    input  logic       bit_i,
    output logic [1:0] rem_next_o,
    output logic       zero_next_o
);

    logic [1:0] rem_q;
    logic [1:0] rem_d;

    always_comb begin
        rem_next_o  = mod3_next(rem_q, bit_i);
        zero_next_o = (rem_next_o == R0);
        rem_d       = rem_q;
        if (clr_i) begin
            rem_d = R0;
        end else if (step_i) begin
            rem_d = rem_next_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= R0;
        end else begin
            rem_q <= rem_d;
        end
    end

endmodule

// File: rtl/mod3_serial_tx.sv
// Parallel-to-serial transmitter with detector clear pulse, per-bit expected y and word verdict.
module mod3_serial_tx
    import mod3_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             rx_clr,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             exp_y,
    output logic             done,
    output logic             div3
);

    localparam int unsigned    CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             div3_q, div3_d;

    logic             accept;
    logic             in_shift;
    logic             msb;
    logic [1:0]       rem_next;
    logic             zero_next;

    assign in_shift = (state_q == StShift);
    assign msb      = shift_q[WIDTH-1];

    mod3_rem_track u_rem_track (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (state_q == StClr),
        .step_i      (in_shift),
        .bit_i       (msb),
        .rem_next_o  (rem_next),
        .zero_next_o (zero_next)
    );

    always_comb begin
        load_ready = (state_q == StIdle) || (state_q == StDone);
        accept     = load_valid && load_ready;
        rx_clr     = (state_q == StClr);
        ser_valid  = in_shift;
        ser_out    = in_shift && msb;
        ser_last   = in_shift && (cnt_q == '0);
        exp_y      = in_shift && zero_next;
        done       = (state_q == StDone);
        div3       = div3_q;
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        div3_d  = div3_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StClr;
                end
            end
            StClr: begin
                state_d = StShift;
            end
            StShift: begin
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                if (cnt_q == '0) begin
                    state_d = StDone;
                    div3_d  = (rem_next == R0);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                state_d = accept ? StClr : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Accept is only possible in IDLE/DONE, so this never disturbs a running frame.
        if (accept) begin
            shift_d = data_in;
            cnt_d   = CntLoad;
            div3_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            div3_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            div3_q  <= div3_d;
        end
    end

endmodule

// File: tb/tb_mod3_serial_tx.sv
// Self-checking bench for mod3_serial_tx (WIDTH = 8) with a prefix-arithmetic reference model.
module tb_mod3_serial_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data_in;
    logic         load_valid;
    logic         load_ready, rx_clr, ser_out, ser_valid, ser_last, exp_y, done, div3;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    int acc_q[$];

    int det_rem = 0;
    logic det_y;

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_ser;
        logic [7:0] exp_y;
        logic       div3;
    } vec_t;

    vec_t vecs[5];

    mod3_serial_tx #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .rx_clr     (rx_clr),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .ser_last   (ser_last),
        .exp_y      (exp_y),
        .done       (done),
        .div3       (div3)
    );

    always #5 clk = ~clk;

    // Reference detector: remainder of the bits seen since rx_clr.
    assign det_y = (((det_rem * 2) + int'(ser_out)) % 3) == 0;

    always @(posedge clk) begin
        cyc++;
        if (!rst && load_valid && load_ready) begin
            acc_cnt++;
            acc_q.push_back(cyc);
        end
        if (done) done_cnt++;
        if (rx_clr) det_rem <= 0;
        else        det_rem <= ((det_rem * 2) + int'(ser_out)) % 3;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model_y(input logic [7:0] w);
        logic [7:0] y;
        int unsigned p;
        for (int k = 0; k < 8; k++) begin
            p = int'(w) >> (7 - k);
            y[7-k] = ((p % 3) == 0);
        end
        return y;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_load_ready"}, load_ready, 1);
        chk({tag, "_rx_clr"}, rx_clr, 0);
        chk({tag, "_ser_valid"}, ser_valid, 0);
        chk({tag, "_ser_out"}, ser_out, 0);
        chk({tag, "_ser_last"}, ser_last, 0);
        chk({tag, "_exp_y"}, exp_y, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_div3"}, div3, 0);
    endtask

    task automatic run_frame(input logic [7:0] w, input logic [7:0] es, input logic [7:0] ey,
                             input logic d3, input bit disturb);
        int n;
        int a0;
        data_in    = w;
        load_valid = 1'b1;
        n = 0;
        while (!load_ready && n < 50) begin
            step();
            n++;
        end
        chk("accept_ready", load_ready, 1);
        a0 = acc_cnt;
        step();
        load_valid = 1'b0;
        chk("clr_rx_clr", rx_clr, 1);
        chk("clr_ser_valid", ser_valid, 0);
        chk("clr_load_ready", load_ready, 0);
        chk("clr_div3", div3, 0);
        for (int k = 0; k < 8; k++) begin
            if (disturb) begin
                data_in    = 8'($urandom);
                load_valid = 1'($urandom_range(0, 1));
            end
            step();
            chk("bit_valid", ser_valid, 1);
            chk("bit_out", ser_out, es[7-k]);
            chk("bit_last", ser_last, (k == 7));
            chk("bit_exp_y", exp_y, ey[7-k]);
            chk("bit_det_y", det_y, exp_y);
            chk("bit_done", done, 0);
        end
        load_valid = 1'b0;
        step();
        chk("done_pulse", done, 1);
        chk("done_div3", div3, d3);
        chk("done_ready", load_ready, 1);
        chk("done_ser_valid", ser_valid, 0);
        chk("accepts_per_frame", acc_cnt - a0, 1);
    endtask

    initial begin
        logic [7:0] w;
        int t0, t1, dn0;

        vecs[0] = '{8'h06, 8'h06, 8'b11111011, 1'b1};
        vecs[1] = '{8'h07, 8'h07, 8'b11111010, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 8'b01010101, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 8'b11111111, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 8'b00000000, 1'b0};

        rst = 1'b1;
        load_valid = 1'b0;
        data_in = '0;
        step();
        step();
        chk_idle("reset");
        rst = 1'b0;
        step();
        chk_idle("idle");

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].data, vecs[i].exp_ser, vecs[i].exp_y, vecs[i].div3, 1'b0);
        end
        step();
        chk_idle("after_table");

        // Back-to-back: load_valid held, data_in swapped right after the first accept.
        acc_q.delete();
        data_in = 8'h06;
        load_valid = 1'b1;
        step();
        data_in = 8'h07;
        for (int k = 0; k < 9; k++) step();
        chk("b2b_done1", done, 1);
        chk("b2b_div3_1", div3, 1);
        step();
        chk("b2b_rx_clr", rx_clr, 1);
        chk("b2b_div3_cleared", div3, 0);
        for (int k = 0; k < 8; k++) step();
        load_valid = 1'b0;
        step();
        chk("b2b_done2", done, 1);
        chk("b2b_div3_2", div3, 0);
        chk("b2b_accepts", acc_q.size(), 2);
        if (acc_q.size() >= 2) begin
            t0 = acc_q[0];
            t1 = acc_q[1];
            chk("b2b_spacing", t1 - t0, 10);
        end
        step();

        // Reset during the 4th bit abandons the frame.
        dn0 = done_cnt;
        data_in = 8'h06;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("mid_bit3_valid", ser_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("mid_reset");
        for (int k = 0; k < 12; k++) step();
        chk("mid_no_done", done_cnt - dn0, 0);
        run_frame(8'h09, 8'h09, model_y(8'h09), 1'b1, 1'b0);

        // Accept coinciding with reset is dropped.
        step();
        rst = 1'b1;
        load_valid = 1'b1;
        data_in = 8'hA5;
        step();
        rst = 1'b0;
        load_valid = 1'b0;
        chk("rst_acc_rx_clr", rx_clr, 0);
        chk("rst_acc_ready", load_ready, 1);
        step();
        chk("rst_acc_still_idle", rx_clr, 0);
        chk("rst_acc_no_valid", ser_valid, 0);

        // Randomized words, some with load_valid/data_in noise during SHIFT.
        for (int i = 0; i < 24; i++) begin
            w = 8'($urandom);
            run_frame(w, w, model_y(w), ((int'(w) % 3) == 0), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod3_serial_tx.md
# mod3_serial_tx

Serial transmitter for our MSB-first divisible-by-3 detector. It accepts a parallel word over a valid/ready handshake and emits it one bit per cycle, MSB first, together with a clear pulse that returns the detector to its remainder-0 state before each frame. It also drives the detector output expected for every bit and a registered divisibility verdict per word, so a bench or a self-checking wrapper can compare directly against the detector.

## Interface
- `WIDTH`, default 8: bits per word, legal range 2..32.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `data_in`  in  WIDTH  word to send; sampled only on accept.
- `load_valid`  in  1  word offered.
- `load_ready`  out  1  high in IDLE and DONE only; accept = `load_valid && load_ready` at a rising edge.
- `rx_clr`  out  1  one-cycle pulse; drives the detector's `rst`.
- `ser_out`  out  1  serial bit (detector `x`).
- `ser_valid`  out  1  `ser_out` is a frame bit this cycle.
- `ser_last`  out  1  current bit is the LSB.
- `exp_y`  out  1  expected detector `y` for the current bit.
- `done`  out  1  one-cycle pulse after the last bit.
- `div3`  out  1  1 if the last completed word mod 3 == 0. Held until the next accept.

## Operation
- States:
  - IDLE: `load_ready` = 1. Accept moves to CLR.
  - CLR: one cycle; `rx_clr` = 1, `ser_valid` = 0. Shift register already holds the word; remainder cleared to 0. Moves to SHIFT.
  - SHIFT: exactly WIDTH cycles.
    - `ser_out` = shift-register MSB; the register shifts left (zero fill) each cycle.
    - Down-counter loaded with WIDTH-1 on accept; `ser_last` = 1 when it reads 0, then the state moves to DONE.
  - DONE: one cycle; `done` = 1, `load_ready` = 1.
    - Accept here moves to CLR (back-to-back operation).
    - Otherwise moves to IDLE.
- Remainder tracker: 2-bit register r in {0,1,2}. In SHIFT, r_next = (2r + bit) mod 3:
  - r=0: bit 0 → 0, bit 1 → 1.
  - r=1: bit 0 → 2, bit 1 → 0.
  - r=2: bit 0 → 1, bit 1 → 2.
  - Encoding 3 is unreachable; if it occurs, treat it as 0.
- `exp_y` = `ser_valid` && (r_next == 0). This is combinational from registered state and the shift-register MSB, with no input paths.
- `div3` is loaded in the last SHIFT cycle with (r_next == 0), so it is valid in DONE. It is cleared to 0 on accept.
- `load_valid` outside IDLE/DONE is ignored. `data_in` changes after accept have no effect.
- Counter width: $clog2(WIDTH).

## Timing
- Reset (the cycle after `rst` is sampled high, including mid-frame):
  - state IDLE; `load_ready` = 1.
  - `rx_clr`, `ser_out`, `ser_valid`, `ser_last`, `exp_y`, `done`, `div3` all 0; r = 0; counter = 0.
  - A frame cut by reset is abandoned, with no `done`.
- Accept at edge t: CLR during cycle t+1. Bit k (k = 0 is the MSB) during cycle t+2+k. DONE during cycle t+2+WIDTH.
- Throughput: WIDTH+2 cycles per word when `load_valid` is held high.
- Detector alignment: `rx_clr` in cycle t+1 puts the detector in s0 for cycle t+2. Its Mealy `y` in cycle t+2+k must equal `exp_y`.
- `rst` and `load_valid` high in the same cycle: reset wins and the word is not accepted.

## Structure
- Package `mod3_pkg`:
  - state enum (IDLE, CLR, SHIFT, DONE);
  - remainder constants R0 = 2'b00, R1 = 2'b01, R2 = 2'b10;
  - function `mod3_next(rem, bit)`.
- Sub-module `mod3_rem_track`: 2-bit remainder register with `clr` and `step` enables, plus outputs `rem_next` and `zero_next`.
- FSM, shift register and counter stay in the top module.

## Test plan
- WIDTH=8, `data_in` = 8'h06 → `ser_out` 0,0,0,0,0,1,1,0; `exp_y` 1,1,1,1,1,0,1,1; `ser_last` on bit 7; `done` pulse; `div3` = 1.
- 8'h07 → `ser_out` 0,0,0,0,0,1,1,1; `exp_y` 1,1,1,1,1,0,1,0; `div3` = 0.
- 8'hFF → `ser_out` all 1; `exp_y` 0,1,0,1,0,1,0,1; `div3` = 1. Connected detector `y` matches `exp_y` every SHIFT cycle.
- `load_valid` held high with 8'h06 then 8'h07 → accepts exactly 10 cycles apart; `rx_clr` directly after the first DONE cycle; `div3` 1 then 0.
- `rst` during the 4th bit → next cycle IDLE, `ser_valid` = 0, `load_ready` = 1, `div3` = 0, no `done`. A new word then sends correctly.
- `load_valid` pulsed and `data_in` changed during SHIFT → no accept and an unchanged bit stream. Accept in the same cycle as `rst` → ignored.
